// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//   Recovers frame timing from a VGA sync stream sampled on a pixel strobe,
//   locks once the measured line/frame lengths match the configured timing,
//   and emits the captured active-area pixels with their coordinates.
//
// Ports
//   CLOCK_50            in   system clock, rising edge
//   RESET               in   synchronous active-high reset
//   PIX_EN              in   pixel strobe; VGA inputs sampled only when high
//   VGA_HS, VGA_VS      in   active-low syncs
//   VGA_BLANK_N         in   high inside the active area
//   VGA_R/G/B [7:0]     in   pixel colour
//   PIX_X/Y   [9:0]     out  coordinates of the captured pixel
//   PIX_R/G/B [7:0]     out  captured colour
//   PIX_VALID           out  one-cycle qualifier for PIX_X/Y/R/G/B
//   LOCKED              out  timing matches the parameters
//   FRAME_START         out  one-cycle pulse per good frame while locked
//   SYNC_ERR            out  one-cycle pulse on a timing violation
//   FRAME_COUNT [15:0]  out  locked frames received (wrapping)
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2,
    parameter int H_TIMEOUT   = 1600
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        PIX_EN,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_N,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    output logic [9:0]  PIX_X,
    output logic [9:0]  PIX_Y,
    output logic [7:0]  PIX_R,
    output logic [7:0]  PIX_G,
    output logic [7:0]  PIX_B,
    output logic        PIX_VALID,
    output logic        LOCKED,
    output logic        FRAME_START,
    output logic        SYNC_ERR,
    output logic [15:0] FRAME_COUNT
);

    localparam int              HW       = $clog2(H_TIMEOUT + 1);
    localparam logic [HW-1:0]   H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]   H_PRE_TO = HW'(H_TIMEOUT - 1);
    localparam logic [HW-1:0]   H_SAT    = HW'(H_TIMEOUT);
    localparam logic [15:0]     V_LINES  = 16'(V_TOTAL);
    localparam logic [3:0]      LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} state_t;

    state_t        state_q, state_d;
    logic          hs_prev_q, vs_prev_q;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [15:0]   line_cnt_q, line_cnt_d, line_inc;
    logic [3:0]    good_q, good_d;
    logic [9:0]    x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic          line_act_q, line_act_d, frame_act_q, frame_act_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          hs_fall, vs_fall, err, start_d, valid_d;
    logic          start_q, err_q, valid_q;
    logic [9:0]    pix_x_q, pix_y_q;
    logic [7:0]    pix_r_q, pix_g_q, pix_b_q;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // Edge detection and timing checks for the current sample.
    always_comb begin
        hs_fall  = PIX_EN & ~VGA_HS & hs_prev_q;
        vs_fall  = PIX_EN & ~VGA_VS & vs_prev_q;
        // Line count as seen by the frame check includes this sample's HS edge.
        line_inc = (hs_fall && line_cnt_q != 16'hFFFF) ? line_cnt_q + 16'd1 : line_cnt_q;
        // Timeout fires only on the sample that reaches the limit, so a stuck
        // HS raises exactly one error.
        err      = (state_q != ST_SEARCH) &&
                   ((hs_fall && h_cnt_q != H_LAST) ||
                    (PIX_EN && !hs_fall && h_cnt_q == H_PRE_TO) ||
                    (vs_fall && line_inc != V_LINES));
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        start_d = 1'b0;
        fcnt_d  = fcnt_q;
        if (err) begin
            state_d = ST_SEARCH;
            good_d  = '0;
        end else if (vs_fall) begin
            unique case (state_q)
                ST_SEARCH: begin
                    state_d = ST_TRACK;
                    good_d  = '0;
                end
                ST_TRACK: begin
                    good_d = good_q + 4'd1;
                    if (good_q + 4'd1 >= LOCK_N) begin
                        state_d = ST_LOCKED;
                        start_d = 1'b1;
                        fcnt_d  = fcnt_q + 16'd1;
                    end
                end
                ST_LOCKED: begin
                    start_d = 1'b1;
                    fcnt_d  = fcnt_q + 16'd1;
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // Counters and active-pixel coordinate tracking.
    always_comb begin
        h_cnt_d     = h_cnt_q;
        line_cnt_d  = line_cnt_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        line_act_d  = line_act_q;
        frame_act_d = frame_act_q;
        valid_d     = 1'b0;
        if (PIX_EN) begin
            h_cnt_d     = hs_fall ? '0 : ((h_cnt_q == H_SAT) ? h_cnt_q : h_cnt_q + HW'(1));
            line_cnt_d  = vs_fall ? '0 : line_inc;
            // An edge on this sample starts a new line/frame before the pixel is placed.
            line_act_d  = line_act_q & ~hs_fall;
            frame_act_d = frame_act_q & ~vs_fall;
            if (VGA_BLANK_N) begin
                if (line_act_d) begin
                    x_cnt_d = sat_inc(x_cnt_q);
                end else begin
                    x_cnt_d = '0;
                    y_cnt_d = frame_act_d ? sat_inc(y_cnt_q) : '0;
                end
                line_act_d  = 1'b1;
                frame_act_d = 1'b1;
                valid_d     = (state_q == ST_LOCKED);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            hs_prev_q   <= 1'b1;
            vs_prev_q   <= 1'b1;
            h_cnt_q     <= '0;
            line_cnt_q  <= '0;
            good_q      <= '0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            line_act_q  <= 1'b0;
            frame_act_q <= 1'b0;
            fcnt_q      <= '0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_r_q     <= '0;
            pix_g_q     <= '0;
            pix_b_q     <= '0;
        end else begin
            if (PIX_EN) begin
                hs_prev_q <= VGA_HS;
                vs_prev_q <= VGA_VS;
            end
            h_cnt_q     <= h_cnt_d;
            line_cnt_q  <= line_cnt_d;
            good_q      <= good_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            line_act_q  <= line_act_d;
            frame_act_q <= frame_act_d;
            fcnt_q      <= fcnt_d;
            start_q     <= start_d;
            err_q       <= err;
            valid_q     <= valid_d;
            if (valid_d) begin
                pix_x_q <= x_cnt_d;
                pix_y_q <= y_cnt_d;
                pix_r_q <= VGA_R;
                pix_g_q <= VGA_G;
                pix_b_q <= VGA_B;
            end
        end
    end

    assign LOCKED      = (state_q == ST_LOCKED);
    assign FRAME_START = start_q;
    assign SYNC_ERR    = err_q;
    assign FRAME_COUNT = fcnt_q;
    assign PIX_VALID   = valid_q;
    assign PIX_X       = pix_x_q;
    assign PIX_Y       = pix_y_q;
    assign PIX_R       = pix_r_q;
    assign PIX_G       = pix_g_q;
    assign PIX_B       = pix_b_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver using a reduced 20x10 timing with a 12x6
// active area (columns 4..15, lines 2..7); PIX_EN strobes every 2nd cycle and
// the VGA inputs carry random junk on the non-strobe cycles.
module tb_vga_sync_receiver;

    localparam int H_TOTAL     = 20;
    localparam int V_TOTAL     = 10;
    localparam int LOCK_FRAMES = 2;
    localparam int H_TIMEOUT   = 40;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic        PIX_EN = 1'b0;
    logic        VGA_HS = 1'b1;
    logic        VGA_VS = 1'b1;
    logic        VGA_BLANK_N = 1'b0;
    logic [7:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
    logic [9:0]  PIX_X, PIX_Y;
    logic [7:0]  PIX_R, PIX_G, PIX_B;
    logic        PIX_VALID, LOCKED, FRAME_START, SYNC_ERR;
    logic [15:0] FRAME_COUNT;

    vga_sync_receiver #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .LOCK_FRAMES(LOCK_FRAMES), .H_TIMEOUT(H_TIMEOUT)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .PIX_EN(PIX_EN),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_R(PIX_R), .PIX_G(PIX_G), .PIX_B(PIX_B),
        .PIX_VALID(PIX_VALID), .LOCKED(LOCKED), .FRAME_START(FRAME_START),
        .SYNC_ERR(SYNC_ERR), .FRAME_COUNT(FRAME_COUNT)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic        locked;
        logic        fstart;
        logic        serr;
        logic [15:0] fcnt;
        logic        valid;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } exp_t;

    exp_t  sb_q[$];
    int    total = 0;
    int    bad = 0;
    int    serr_seen = 0, fs_seen = 0, pv_seen = 0;
    string phase = "reset";

    // Reference model state: 0 search, 1 track, 2 locked.
    int         m_state, m_good, m_h, m_l, m_fc;
    logic       m_hp, m_vp;
    logic [9:0] m_x, m_y;
    logic [7:0] m_r, m_g, m_b;

    function automatic exp_t cur_exp(input logic fs, input logic se, input logic v);
        exp_t e;
        e.locked = (m_state == 2);
        e.fstart = fs;
        e.serr   = se;
        e.fcnt   = 16'(m_fc);
        e.valid  = v;
        e.x = m_x; e.y = m_y; e.r = m_r; e.g = m_g; e.b = m_b;
        return e;
    endfunction

    task automatic check_edge();
        exp_t e;
        logic [18:0] st_o, st_e;
        logic [44:0] px_o, px_e;
        @(posedge CLOCK_50);
        #1;
        e    = sb_q.pop_front();
        st_o = {LOCKED, FRAME_START, SYNC_ERR, FRAME_COUNT};
        st_e = {e.locked, e.fstart, e.serr, e.fcnt};
        px_o = {PIX_VALID, PIX_X, PIX_Y, PIX_R, PIX_G, PIX_B};
        px_e = {e.valid, e.x, e.y, e.r, e.g, e.b};
        total++;
        assert (st_o === st_e) else begin
            bad++;
            $error("FAIL %s status got=%h exp=%h", phase, st_o, st_e);
        end
        total++;
        assert (px_o === px_e) else begin
            bad++;
            $error("FAIL %s pixel got=%h exp=%h", phase, px_o, px_e);
        end
        serr_seen += int'(SYNC_ERR);
        fs_seen   += int'(FRAME_START);
        pv_seen   += int'(PIX_VALID);
    endtask

    task automatic check_val(input string tag, input int got, input int exp_v);
        total++;
        assert (got === exp_v) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp_v);
        end
    endtask

    task automatic idle();
        PIX_EN      = 1'b0;
        VGA_HS      = 1'($urandom);
        VGA_VS      = 1'($urandom);
        VGA_BLANK_N = 1'($urandom);
        VGA_R = 8'($urandom); VGA_G = 8'($urandom); VGA_B = 8'($urandom);
        sb_q.push_back(cur_exp(1'b0, 1'b0, 1'b0));
        check_edge();
    endtask

    task automatic sample(input logic hs, input logic vs, input logic bl, input int x, input int y);
        logic [7:0] r, g, b;
        logic hf, vf, er, fs, v;
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        hf = !hs && m_hp;
        vf = !vs && m_vp;
        er = 1'b0;
        fs = 1'b0;
        if (m_state != 0) begin
            if (hf && m_h != H_TOTAL - 1) er = 1'b1;
            if (!hf && m_h == H_TIMEOUT - 1) er = 1'b1;
            if (vf && (m_l + int'(hf)) != V_TOTAL) er = 1'b1;
        end
        v = bl && (m_state == 2);
        if (v) begin
            m_x = 10'(x); m_y = 10'(y); m_r = r; m_g = g; m_b = b;
        end
        if (er) begin
            m_state = 0; m_good = 0;
        end else if (vf) begin
            if (m_state == 0) begin
                m_state = 1; m_good = 0;
            end else begin
                if (m_state == 1) m_good++;
                if (m_state == 2 || m_good >= LOCK_FRAMES) begin
                    m_state = 2; fs = 1'b1; m_fc++;
                end
            end
        end
        m_h  = hf ? 0 : ((m_h < H_TIMEOUT) ? m_h + 1 : m_h);
        m_l  = vf ? 0 : m_l + int'(hf);
        m_hp = hs;
        m_vp = vs;
        PIX_EN = 1'b1; VGA_HS = hs; VGA_VS = vs; VGA_BLANK_N = bl;
        VGA_R = r; VGA_G = g; VGA_B = b;
        sb_q.push_back(cur_exp(fs, er, v));
        check_edge();
        idle();
    endtask

    task automatic drive_line(input int len, input bit vs_low, input bit act, input int y);
        for (int h = 0; h < len; h++) begin
            sample(h >= 2, !vs_low, act && h >= 4 && h < 16, h - 4, y);
        end
    endtask

    task automatic drive_frame(input int lines, input int short_idx, input int long_idx);
        int len;
        for (int v = 0; v < lines; v++) begin
            len = (v == short_idx) ? H_TOTAL - 1 : ((v == long_idx) ? H_TIMEOUT + 10 : H_TOTAL);
            drive_line(len, v < 2, v >= 2 && v < 8 && v != long_idx, v - 2);
        end
    endtask

    task automatic do_reset(input int cycles);
        RESET = 1'b1;
        PIX_EN = 1'b1; VGA_HS = 1'b0; VGA_VS = 1'b0; VGA_BLANK_N = 1'b1;
        m_state = 0; m_good = 0; m_h = 0; m_l = 0; m_fc = 0;
        m_hp = 1'b1; m_vp = 1'b1;
        m_x = '0; m_y = '0; m_r = '0; m_g = '0; m_b = '0;
        for (int i = 0; i < cycles; i++) begin
            sb_q.push_back(cur_exp(1'b0, 1'b0, 1'b0));
            check_edge();
        end
        RESET = 1'b0;
    endtask

    task automatic clear_counts();
        serr_seen = 0; fs_seen = 0; pv_seen = 0;
    endtask

    initial begin
        do_reset(2);

        phase = "ideal";
        clear_counts();
        for (int f = 0; f < 4; f++) drive_frame(V_TOTAL, -1, -1);
        check_val("ideal_fcount", int'(FRAME_COUNT), 2);
        check_val("ideal_locked", int'(LOCKED), 1);
        check_val("ideal_fstarts", fs_seen, 2);
        check_val("ideal_serr", serr_seen, 0);

        phase = "pixels";
        clear_counts();
        drive_frame(V_TOTAL, -1, -1);
        check_val("pix_per_frame", pv_seen, 72);

        phase = "short_line";
        clear_counts();
        drive_frame(V_TOTAL, 4, -1);
        check_val("short_serr", serr_seen, 1);
        check_val("short_unlocked", int'(LOCKED), 0);
        for (int f = 0; f < 3; f++) drive_frame(V_TOTAL, -1, -1);
        check_val("short_relock", int'(LOCKED), 1);

        phase = "short_frame";
        drive_frame(V_TOTAL - 1, -1, -1);
        clear_counts();
        drive_frame(V_TOTAL, -1, -1);
        check_val("sframe_serr", serr_seen, 1);
        check_val("sframe_no_fstart", fs_seen, 0);
        for (int f = 0; f < 3; f++) drive_frame(V_TOTAL, -1, -1);
        check_val("sframe_relock", int'(LOCKED), 1);

        phase = "timeout";
        clear_counts();
        drive_frame(V_TOTAL, -1, 3);
        check_val("timeout_serr", serr_seen, 1);
        check_val("timeout_unlocked", int'(LOCKED), 0);
        for (int f = 0; f < 3; f++) drive_frame(V_TOTAL, -1, -1);
        check_val("timeout_relock", int'(LOCKED), 1);

        phase = "midreset";
        for (int v = 0; v < 4; v++) drive_line(H_TOTAL, v < 2, v >= 2, v - 2);
        drive_line(7, 1'b0, 1'b1, 2);
        do_reset(1);
        clear_counts();
        drive_line(15, 1'b0, 1'b0, 0);
        drive_frame(V_TOTAL, -1, -1);
        drive_frame(V_TOTAL, -1, -1);
        check_val("midreset_no_valid", pv_seen, 0);
        drive_frame(V_TOTAL, -1, -1);
        drive_frame(V_TOTAL, -1, -1);
        check_val("midreset_relock", int'(LOCKED), 1);
        check_val("midreset_fcount", int'(FRAME_COUNT), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, pixel periods per line (HS falling edge to HS falling edge).
REQ-002 SHALL have parameter V_TOTAL, default 525, lines per frame (VS falling edge to VS falling edge).
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames required to lock (range 1-15).
REQ-004 SHALL have parameter H_TIMEOUT, default 1600, pixel samples without an HS falling edge before an error.
REQ-005 SHALL use one clock, CLOCK_50, with a synchronous, active-high reset, RESET.
REQ-006 CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-007 RESET  in  1  synchronous active-high reset.
REQ-008 PIX_EN  in  1  one-cycle pixel strobe; VGA inputs are sampled only on cycles where PIX_EN=1.
REQ-009 VGA_HS, VGA_VS  in  1 each  active-low syncs.
REQ-010 VGA_BLANK_N  in  1  high during the active area.
REQ-011 VGA_R, VGA_G, VGA_B  in  8 each  pixel colour.
REQ-012 PIX_X, PIX_Y  out  10 each  coordinates of the captured active pixel.
REQ-013 PIX_R, PIX_G, PIX_B  out  8 each  captured colour.
REQ-014 PIX_VALID  out  1  one-cycle qualifier for PIX_X/Y/R/G/B.
REQ-015 LOCKED  out  1  timing matches parameters.
REQ-016 FRAME_START  out  1  one-cycle pulse per locked frame.
REQ-017 SYNC_ERR  out  1  one-cycle pulse on timing violation.
REQ-018 FRAME_COUNT  out  16  locked frames received; wraps at 65535 to 0.

Function
REQ-019 Edge detection: HS falling edge = sample with VGA_HS=0 where previous sample was 1; VS likewise; previous-sample registers update only on PIX_EN.
REQ-020 h_cnt: 0 on an HS falling-edge sample, else +1 per sample, saturating at H_TIMEOUT.
REQ-021 line_cnt: +1 on every HS falling-edge sample, including one coincident with a VS falling edge; cleared to 0 after the frame check of a VS falling-edge sample.
REQ-022 States: SEARCH, TRACK, LOCKED; LOCKED output = (state==LOCKED).
REQ-023 SEARCH: VS falling edge -> TRACK, good_frames=0, line_cnt=0; no error checks.
REQ-024 TRACK/LOCKED line check: at HS falling edge, pre-clear h_cnt SHALL equal H_TOTAL-1, else error.
REQ-025 TRACK/LOCKED timeout: h_cnt reaching H_TIMEOUT SHALL raise an error.
REQ-026 TRACK/LOCKED frame check: at VS falling edge, line_cnt including this sample's increment SHALL equal V_TOTAL, else error.
REQ-027 TRACK: each good VS falling edge increments good_frames; at LOCK_FRAMES -> LOCKED.
REQ-028 Error: SYNC_ERR=1 for one cycle, next state SEARCH, good_frames=0; error takes precedence over a coincident VS edge (no TRACK entry that sample).
REQ-029 FRAME_START pulses, and FRAME_COUNT increments, on each good VS falling edge whose next state is LOCKED, including the locking edge.
REQ-030 PIX_X: 0 on first VGA_BLANK_N=1 sample after an HS falling edge, +1 per further BLANK_N=1 sample on that line, saturating at 1023.
REQ-031 PIX_Y: 0 on first line containing BLANK_N=1 after a VS falling edge, +1 on each subsequent line containing BLANK_N=1, saturating at 1023.
REQ-032 PIX_VALID=1 exactly one CLOCK_50 cycle after a PIX_EN sample with VGA_BLANK_N=1 while state==LOCKED; colour and coordinates registered on the same edge.
REQ-033 When PIX_VALID=0, PIX_X/Y/R/G/B hold their last values.
REQ-034 Status outputs (LOCKED, FRAME_START, SYNC_ERR) SHALL be registered with one-cycle latency from the deciding sample.

Reset
REQ-035 RESET mid-operation SHALL take effect on the next CLOCK_50 edge, overriding PIX_EN and all edges.
REQ-036 After reset: state=SEARCH; all outputs 0; h_cnt=0; line_cnt=0; good_frames=0; previous HS and VS samples=1.

Verification
REQ-037 Feed 3 ideal 800x525 frames, PIX_EN every 2nd cycle -> LOCKED rises after 2nd VS falling edge following the first; FRAME_START once per frame; FRAME_COUNT=2 after 3rd edge; SYNC_ERR never asserts.
REQ-038 When locked, one line of 799 pixels -> SYNC_ERR pulse one cycle after the short HS edge; LOCKED=0; relocks after 2 further good frames.
REQ-039 When locked, frame of 524 lines -> SYNC_ERR at VS edge; FRAME_START not pulsed on that edge.
REQ-040 When locked, HS held high 1600 samples -> SYNC_ERR once; state SEARCH.
REQ-041 When locked, active pixels -> first PIX_VALID carries X=0,Y=0; last of frame X=639,Y=479; exactly 307200 PIX_VALID pulses per frame; colours match stimulus.
REQ-042 RESET asserted mid-line when LOCKED -> next cycle all outputs 0, state SEARCH; no PIX_VALID until relock.
